ysyx_22051468_lsu: RTL and testbench
====================================

# ysyx_22051468_lsu

Load/store unit that sits directly downstream of the execute stage. It accepts one memory operation per request from Exec: load or store, byte/half/word/double, signed or unsigned. It runs a request/grant/response handshake with the data memory and returns aligned, sign- or zero-extended load data to writeback. It replaces the combinational negedge memory access in Exec with a stalling, multi-cycle sequential access.

## Interface
- WIDTH, 64, data and address width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid_i  in  1  Exec presents a memory op
- req_ready_o  out  1  LSU can accept (state IDLE)
- is_load_i / is_store_i  in  1  op kind; both 0 means no memory op
- size_i  in  2  0=B, 1=H, 2=W, 3=D
- unsigned_i  in  1  zero-extend load (ignored for D and stores)
- addr_i  in  WIDTH  effective address (rs1+imm)
- wdata_i  in  WIDTH  store data (rs2)
- rd_addr_i  in  5  load destination
- mem_req_o  out  1  memory request
- mem_we_o  out  1  1=write
- mem_addr_o  out  WIDTH  addr with [2:0] forced to 0
- mem_wdata_o  out  WIDTH  store data shifted into byte lanes
- mem_wmask_o  out  8  byte-lane write mask
- mem_gnt_i  in  1  request accepted this cycle
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  WIDTH  8-byte-aligned read data
- wb_valid_o  out  1  one-cycle writeback pulse
- wb_addr_o  out  5  writeback register
- wb_data_o  out  WIDTH  extended load data
- store_done_o  out  1  one-cycle pulse when a store is granted
- misalign_o  out  1  one-cycle pulse for a misaligned request
- hold_pipeline_o  out  1  stall request to the controller

## Operation
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - req_ready_o=1.
  - An accept is the cycle with req_valid_i & (is_load_i|is_store_i).
  - Aligned accept: latch addr, size, unsigned, rd, wdata and op; go to REQ.
  - Misaligned accept (addr_i not a multiple of 1<<size_i): misalign_o=1 in the next cycle, stay in IDLE, no mem_req.
- REQ:
  - mem_req_o=1; addr, we, wdata and wmask come from the latched values and stay stable until grant.
  - On mem_gnt_i: a store goes to IDLE and pulses store_done_o next cycle; a load goes to WAIT.
- WAIT:
  - mem_req_o=0.
  - mem_rvalid_i is sampled only in WAIT, so rvalid in the grant cycle is ignored.
  - On rvalid: register the extended data and go to IDLE.
  - wb_valid_o=1 the next cycle only if rd≠0. The read is still performed when rd=0.
- Store lanes, with off=addr[2:0]:
  - mem_wdata_o = wdata << (8*off).
  - mem_wmask_o = ({1,3,15,255}[size]) << off.
- Load extract:
  - sh = mem_rdata_i >> (8*off).
  - Keep the low 8/16/32/64 bits per size.
  - Sign-extend from the top kept bit unless unsigned_i; D is passed through unchanged.
- hold_pipeline_o = (state≠IDLE) | (IDLE & aligned accept). It deasserts in the cycle wb_valid_o or store_done_o pulses.
- mem_we_o and mem_wmask_o are 0 whenever mem_req_o=0.

## Timing
- Reset (asynchronous): state IDLE. All outputs are 0 except req_ready_o=1. Latched fields are cleared.
- Minimum latency:
  - Load, accept at cycle T: mem_req_o at T+1; with gnt at T+1, WAIT at T+2; with rvalid at T+2, wb_valid_o at T+3.
  - Store: store_done_o at T+2 with gnt at T+1.
- Back-to-back: req_ready_o is 1 in the wb_valid_o/store_done_o cycle, so a new accept is legal there.
- Grant may be delayed any number of cycles. mem_req_o and all mem_* fields hold constant until gnt.
- Reset mid-operation: mem_req_o drops immediately and the FSM returns to IDLE. A later rvalid for the aborted load is ignored, with no wb pulse.
- Pulse outputs (wb_valid_o, store_done_o, misalign_o) are registered and exactly one cycle wide. wb_data_o holds its value until the next load completes.

## Test plan
- LW signed at addr 0x80000004, mem_rdata_i=0x8765432112345678, rd=5, gnt and rvalid each after 1 cycle -> wb_valid_o 1 cycle, wb_addr_o=5, wb_data_o=0xFFFFFFFF87654321. The same op with LWU -> 0x0000000087654321.
- SB at 0x80000003, wdata=0xAB -> mem_addr_o=0x80000000, mem_wmask_o=0x08, mem_wdata_o[31:24]=0xAB, mem_we_o=1; store_done_o pulses one cycle after gnt.
- SH at 0x80000001 -> misalign_o pulses 1 cycle; mem_req_o never asserts; hold_pipeline_o stays 0 after that cycle.
- LD at 0x80000008 with gnt held low for 3 cycles -> mem_req_o high for 4 cycles with constant addr; hold_pipeline_o high throughout; wb_data_o equals mem_rdata_i exactly.
- rst_n pulsed low while in WAIT, then rvalid asserted -> all outputs return to reset values immediately; no wb_valid_o.
- LB to rd=0 followed immediately by SD -> no wb_valid_o for the LB; the SD is accepted in the cycle after the LB's rvalid with mem_wmask_o=0xFF.

Source files
------------

// File: rtl/ysyx_22051468_lsu.sv
// ysyx_22051468_lsu: load/store unit between Exec and writeback.
// Accepts one memory op per request and runs a req/gnt/rvalid handshake with
// data memory. Load data comes back lane-aligned and sign/zero extended.
// Ports:
//   req_valid_i/req_ready_o, is_load_i, is_store_i, size_i, unsigned_i,
//   addr_i, wdata_i, rd_addr_i          : request from Exec
//   mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wmask_o,
//   mem_gnt_i, mem_rvalid_i, mem_rdata_i : data memory handshake
//   wb_valid_o, wb_addr_o, wb_data_o     : load writeback (registered)
//   store_done_o, misalign_o             : one-cycle status pulses (registered)
//   hold_pipeline_o                      : stall request to the controller
module ysyx_22051468_lsu #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic [1:0]       size_i,
  input  logic             unsigned_i,
  input  logic [WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [4:0]       rd_addr_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [WIDTH-1:0] mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  output logic [7:0]       mem_wmask_o,
  input  logic             mem_gnt_i,
  input  logic             mem_rvalid_i,
  input  logic [WIDTH-1:0] mem_rdata_i,
  output logic             wb_valid_o,
  output logic [4:0]       wb_addr_o,
  output logic [WIDTH-1:0] wb_data_o,
  output logic             store_done_o,
  output logic             misalign_o,
  output logic             hold_pipeline_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e           r_state;
  state_e           w_state_next;

  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [1:0]       r_size;
  logic             r_unsigned;
  logic             r_we;
  logic [4:0]       r_rd;

  logic             w_accept;
  logic             w_misalign;
  logic [5:0]       w_shamt;
  logic [7:0]       w_wmask_base;
  logic [WIDTH-1:0] w_rsh;
  logic [WIDTH-1:0] w_ext;

  assign w_accept = req_valid_i & (is_load_i | is_store_i);

  // Natural alignment: low address bits below the access size must be zero.
  always_comb begin
    w_misalign = 1'b0;
    case (size_i)
      2'd0:    w_misalign = 1'b0;
      2'd1:    w_misalign = addr_i[0];
      2'd2:    w_misalign = |addr_i[1:0];
      default: w_misalign = |addr_i[2:0];
    endcase
  end

  // Byte-lane offset within the 8-byte memory word, expressed in bits.
  assign w_shamt = {r_addr[2:0], 3'b000};

  assign mem_addr_o  = {r_addr[WIDTH-1:3], 3'b000};
  assign mem_wdata_o = r_wdata << w_shamt;

  always_comb begin
    w_wmask_base = 8'h00;
    case (r_size)
      2'd0:    w_wmask_base = 8'h01;
      2'd1:    w_wmask_base = 8'h03;
      2'd2:    w_wmask_base = 8'h0F;
      default: w_wmask_base = 8'hFF;
    endcase
  end

  // Load extract: shift the addressed lane down, then extend from its top bit.
  assign w_rsh = mem_rdata_i >> w_shamt;

  always_comb begin
    w_ext = w_rsh;
    case (r_size)
      2'd0:    w_ext = {{(WIDTH-8){~r_unsigned & w_rsh[7]}},   w_rsh[7:0]};
      2'd1:    w_ext = {{(WIDTH-16){~r_unsigned & w_rsh[15]}}, w_rsh[15:0]};
      2'd2:    w_ext = {{(WIDTH-32){~r_unsigned & w_rsh[31]}}, w_rsh[31:0]};
      default: w_ext = w_rsh;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and state-decoded handshake outputs.
  always_comb begin
    w_state_next    = r_state;
    req_ready_o     = 1'b0;
    mem_req_o       = 1'b0;
    mem_we_o        = 1'b0;
    mem_wmask_o     = 8'h00;
    hold_pipeline_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (w_accept && !w_misalign) begin
          hold_pipeline_o = 1'b1;
          w_state_next    = S_REQ;
        end
      end
      S_REQ: begin
        mem_req_o       = 1'b1;
        mem_we_o        = r_we;
        mem_wmask_o     = w_wmask_base << r_addr[2:0];
        hold_pipeline_o = 1'b1;
        if (mem_gnt_i) w_state_next = r_we ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        hold_pipeline_o = 1'b1;
        if (mem_rvalid_i) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Request capture on an aligned accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_we       <= 1'b0;
      r_rd       <= 5'd0;
    end else if (r_state == S_IDLE && w_accept && !w_misalign) begin
      r_addr     <= addr_i;
      r_wdata    <= wdata_i;
      r_size     <= size_i;
      r_unsigned <= unsigned_i;
      r_we       <= is_store_i;
      r_rd       <= rd_addr_i;
    end
  end

  // Registered pulses and writeback data; wb_data_o holds until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      misalign_o   <= 1'b0;
      store_done_o <= 1'b0;
      wb_valid_o   <= 1'b0;
      wb_addr_o    <= 5'd0;
      wb_data_o    <= '0;
    end else begin
      misalign_o   <= (r_state == S_IDLE) & w_accept & w_misalign;
      store_done_o <= (r_state == S_REQ) & mem_gnt_i & r_we;
      wb_valid_o   <= (r_state == S_WAIT) & mem_rvalid_i & (r_rd != 5'd0);
      if (r_state == S_WAIT && mem_rvalid_i) begin
        wb_addr_o <= r_rd;
        wb_data_o <= w_ext;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22051468_lsu.sv
module tb_ysyx_22051468_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i, req_ready_o;
  logic        is_load_i, is_store_i;
  logic [1:0]  size_i;
  logic        unsigned_i;
  logic [63:0] addr_i, wdata_i;
  logic [4:0]  rd_addr_i;
  logic        mem_req_o, mem_we_o;
  logic [63:0] mem_addr_o, mem_wdata_o;
  logic [7:0]  mem_wmask_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [63:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_addr_o;
  logic [63:0] wb_data_o;
  logic        store_done_o, misalign_o, hold_pipeline_o;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_wb;

  ysyx_22051468_lsu #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .is_load_i(is_load_i), .is_store_i(is_store_i),
    .size_i(size_i), .unsigned_i(unsigned_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .rd_addr_i(rd_addr_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .wb_valid_o(wb_valid_o), .wb_addr_o(wb_addr_o), .wb_data_o(wb_data_o),
    .store_done_o(store_done_o), .misalign_o(misalign_o),
    .hold_pipeline_o(hold_pipeline_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: extract nbytes from the addressed lane, then extend.
  function automatic logic [63:0] ref_load(input logic [63:0] rdata, input int off,
                                           input int size, input bit uns);
    int nb;
    logic [63:0] v, keep;
    nb = 1 << size;
    v  = rdata >> (8 * off);
    if (nb == 8) return v;
    keep = (64'd1 << (8 * nb)) - 64'd1;
    v = v & keep;
    if (!uns && v[8*nb-1]) v = v | ~keep;
    return v;
  endfunction

  task automatic clear_req();
    req_valid_i = 1'b0; is_load_i = 1'b0; is_store_i = 1'b0;
  endtask

  // One idle cycle with no request: all pulses must be gone.
  task automatic idle_cycle();
    @(posedge clk); @(negedge clk);
    chk("idle_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("idle_store_done", 64'(store_done_o), 64'd0);
    chk("idle_misalign", 64'(misalign_o), 64'd0);
    chk("idle_hold", 64'(hold_pipeline_o), 64'd0);
    chk("idle_mem_req", 64'(mem_req_o), 64'd0);
  endtask

  // Runs one op starting at a negedge in IDLE; returns at the negedge of the
  // result cycle (pulse cycle, or misalign cycle).
  task automatic do_op(input bit ld, input int size, input bit uns,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [4:0] rd, input logic [63:0] rdata,
                       input int gdly, input int rdly, input bit junk_rv);
    int off, nb;
    bit mis;
    logic [63:0] exp_addr, exp_wdata;
    logic [7:0]  exp_mask;
    off = int'(addr[2:0]);
    nb  = 1 << size;
    mis = (addr % 64'(nb)) != 0;
    exp_addr  = {addr[63:3], 3'b000};
    exp_wdata = wdata << (8 * off);
    exp_mask  = 8'(((1 << nb) - 1) << off);

    req_valid_i = 1'b1; is_load_i = ld; is_store_i = !ld;
    size_i = 2'(size); unsigned_i = uns; addr_i = addr; wdata_i = wdata; rd_addr_i = rd;
    #1;
    chk("accept_ready", 64'(req_ready_o), 64'd1);
    chk("accept_hold", 64'(hold_pipeline_o), 64'(!mis));
    @(posedge clk); #1; clear_req();
    @(negedge clk);
    chk("t1_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("t1_store_done", 64'(store_done_o), 64'd0);
    if (mis) begin
      chk("mis_pulse", 64'(misalign_o), 64'd1);
      chk("mis_mem_req", 64'(mem_req_o), 64'd0);
      chk("mis_hold", 64'(hold_pipeline_o), 64'd0);
      chk("mis_ready", 64'(req_ready_o), 64'd1);
      return;
    end
    chk("t1_misalign", 64'(misalign_o), 64'd0);
    for (int i = 0; i <= gdly; i++) begin
      chk("req_mem_req", 64'(mem_req_o), 64'd1);
      chk("req_addr", mem_addr_o, exp_addr);
      chk("req_we", 64'(mem_we_o), 64'(!ld));
      chk("req_hold", 64'(hold_pipeline_o), 64'd1);
      chk("req_ready0", 64'(req_ready_o), 64'd0);
      if (!ld) begin
        chk("req_wmask", 64'(mem_wmask_o), 64'(exp_mask));
        chk("req_wdata", mem_wdata_o, exp_wdata);
      end
      if (i == gdly) begin
        mem_gnt_i = 1'b1;
        if (junk_rv) begin mem_rvalid_i = 1'b1; mem_rdata_i = 64'($urandom) ^ 64'hDEAD_0000_0000_BEEF; end
      end
      @(posedge clk); #1; mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
      @(negedge clk);
    end
    if (!ld) begin
      chk("st_done", 64'(store_done_o), 64'd1);
      chk("st_mem_req", 64'(mem_req_o), 64'd0);
      chk("st_wmask0", 64'(mem_wmask_o), 64'd0);
      chk("st_hold", 64'(hold_pipeline_o), 64'd0);
      chk("st_ready", 64'(req_ready_o), 64'd1);
      return;
    end
    for (int j = 0; j <= rdly; j++) begin
      chk("wait_mem_req", 64'(mem_req_o), 64'd0);
      chk("wait_we", 64'(mem_we_o), 64'd0);
      chk("wait_wmask", 64'(mem_wmask_o), 64'd0);
      chk("wait_hold", 64'(hold_pipeline_o), 64'd1);
      chk("wait_wb_valid", 64'(wb_valid_o), 64'd0);
      if (j == rdly) begin mem_rvalid_i = 1'b1; mem_rdata_i = rdata; end
      @(posedge clk); #1; mem_rvalid_i = 1'b0;
      @(negedge clk);
    end
    chk("ld_wb_valid", 64'(wb_valid_o), 64'(rd != 5'd0));
    chk("ld_hold", 64'(hold_pipeline_o), 64'd0);
    chk("ld_ready", 64'(req_ready_o), 64'd1);
    if (rd != 5'd0) begin
      chk("ld_wb_addr", 64'(wb_addr_o), 64'(rd));
      chk("ld_wb_data", wb_data_o, ref_load(rdata, off, size, uns));
    end
    last_wb = wb_data_o;
  endtask

  initial begin
    rst_n = 1'b0; clear_req();
    size_i = 2'd0; unsigned_i = 1'b0; addr_i = '0; wdata_i = '0; rd_addr_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(req_ready_o), 64'd1);
    chk("rst_mem_req", 64'(mem_req_o), 64'd0);
    chk("rst_hold", 64'(hold_pipeline_o), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_wb_data", wb_data_o, 64'd0);
    chk("rst_mem_addr", mem_addr_o, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LW / LWU at 0x80000004.
    do_op(1'b1, 2, 1'b0, 64'h8000_0004, 64'd0, 5'd5, 64'h8765_4321_1234_5678, 1, 1, 1'b0);
    chk("lw_literal", last_wb, 64'hFFFF_FFFF_8765_4321);
    idle_cycle();
    do_op(1'b1, 2, 1'b1, 64'h8000_0004, 64'd0, 5'd5, 64'h8765_4321_1234_5678, 1, 1, 1'b0);
    chk("lwu_literal", last_wb, 64'h0000_0000_8765_4321);
    idle_cycle();
    // SB, misaligned SH, LD with delayed grant.
    do_op(1'b0, 0, 1'b0, 64'h8000_0003, 64'hAB, 5'd0, 64'd0, 0, 0, 1'b0);
    idle_cycle();
    do_op(1'b0, 1, 1'b0, 64'h8000_0001, 64'h1234, 5'd0, 64'd0, 0, 0, 1'b0);
    idle_cycle();
    do_op(1'b1, 3, 1'b0, 64'h8000_0008, 64'd0, 5'd9, 64'hFEDC_BA98_7654_3210, 3, 0, 1'b1);
    chk("ld_literal", last_wb, 64'hFEDC_BA98_7654_3210);
    idle_cycle();
    // LB to x0 then SD back-to-back.
    do_op(1'b1, 0, 1'b0, 64'h8000_0002, 64'd0, 5'd0, 64'h0000_0000_0080_0000, 0, 0, 1'b0);
    do_op(1'b0, 3, 1'b0, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 5'd0, 64'd0, 0, 0, 1'b0);
    idle_cycle();

    // Reset while in WAIT; the late rvalid must be ignored.
    req_valid_i = 1'b1; is_load_i = 1'b1; size_i = 2'd3; unsigned_i = 1'b0;
    addr_i = 64'h8000_0020; rd_addr_i = 5'd7;
    @(posedge clk); #1; clear_req();
    @(negedge clk); mem_gnt_i = 1'b1;
    @(posedge clk); #1; mem_gnt_i = 1'b0;
    @(negedge clk);
    chk("abort_pre_hold", 64'(hold_pipeline_o), 64'd1);
    rst_n = 1'b0; #1;
    chk("abort_ready", 64'(req_ready_o), 64'd1);
    chk("abort_hold", 64'(hold_pipeline_o), 64'd0);
    chk("abort_mem_req", 64'(mem_req_o), 64'd0);
    chk("abort_wb_data", wb_data_o, 64'd0);
    chk("abort_mem_addr", mem_addr_o, 64'd0);
    @(negedge clk); rst_n = 1'b1;
    mem_rvalid_i = 1'b1; mem_rdata_i = 64'h1111_2222_3333_4444;
    @(posedge clk); #1; mem_rvalid_i = 1'b0;
    @(negedge clk);
    chk("abort_no_wb", 64'(wb_valid_o), 64'd0);
    chk("abort_wb_data_kept", wb_data_o, 64'd0);
    idle_cycle();

    // Randomized ops.
    for (int k = 0; k < 80; k++) begin
      bit ld, uns, junk;
      int sz, gd, rdl, gap;
      logic [63:0] a, wd, rdat;
      logic [4:0] rd;
      ld   = 1'($urandom_range(0, 1));
      uns  = 1'($urandom_range(0, 1));
      junk = 1'($urandom_range(0, 1));
      sz   = int'($urandom_range(0, 3));
      gd   = int'($urandom_range(0, 3));
      rdl  = int'($urandom_range(0, 3));
      gap  = int'($urandom_range(0, 2));
      a    = {32'd0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << sz) - 1);
      wd   = {$urandom, $urandom};
      rdat = {$urandom, $urandom};
      rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      do_op(ld, sz, uns, a, wd, rd, rdat, gd, rdl, junk);
      for (int g = 0; g < gap; g++) idle_cycle();
    end
    idle_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
